// File: rtl/gate2_bist_ctrl.sv
// Exhaustive BIST controller for a 2-input combinational cell.
// Steps {A,B} through 00,01,10,11 for ITER passes, holds each vector SETTLE cycles,
// samples Y for one cycle and checks it against the TRUTH table.
module gate2_bist_ctrl #(
  parameter logic [3:0]  TRUTH  = 4'b0001,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ITER   = 1,
  parameter int unsigned ERRW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            Y,
  output logic            A,
  output logic            B,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERRCNT,
  output logic [1:0]      FAILVEC,
  output logic            FAILSEEN
);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StFin} state_e;

  localparam logic [7:0]      SettleLast = 8'(SETTLE - 1);
  localparam logic [15:0]     IterLast   = 16'(ITER - 1);
  localparam logic [ERRW-1:0] ErrMax     = '1;

  state_e          state_q, state_d;
  logic [1:0]      v_q, v_d;
  logic [15:0]     pass_cnt_q, pass_cnt_d;
  logic [7:0]      settle_q, settle_d;
  logic            a_q, a_d, b_q, b_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERRW-1:0] errcnt_q, errcnt_d;
  logic [1:0]      failvec_q, failvec_d;
  logic            failseen_q, failseen_d;
  logic            mismatch;

  // Case equality so an X or Z on Y is reported as a mismatch in simulation.
  assign mismatch = !(Y === TRUTH[v_q]);

  // Next-state and registered-output logic for the test sequencer.
  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    errcnt_d   = errcnt_q;
    failvec_d  = failvec_q;
    failseen_d = failseen_q;

    unique case (state_q)
      StIdle: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          state_d    = StApply;
          v_d        = 2'd0;
          pass_cnt_d = 16'd0;
          settle_d   = 8'd0;
          errcnt_d   = '0;
          failvec_d  = 2'd0;
          failseen_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end

      StApply: begin
        if (settle_q == SettleLast) begin
          settle_d = 8'd0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      StSample: begin
        if (mismatch) begin
          if (errcnt_q != ErrMax) errcnt_d = errcnt_q + 1'b1;
          if (!failseen_q) begin
            failseen_d = 1'b1;
            failvec_d  = v_q;
          end
        end
        if (v_q != 2'd3) begin
          v_d        = v_q + 2'd1;
          {a_d, b_d} = v_q + 2'd1;
          state_d    = StApply;
        end else if (pass_cnt_q != IterLast) begin
          v_d        = 2'd0;
          {a_d, b_d} = 2'd0;
          pass_cnt_d = pass_cnt_q + 16'd1;
          state_d    = StApply;
        end else begin
          // Uses errcnt_d so the final sample's verdict is included.
          state_d = StFin;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (errcnt_d == '0);
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      v_q        <= 2'd0;
      pass_cnt_q <= 16'd0;
      settle_q   <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errcnt_q   <= '0;
      failvec_q  <= 2'd0;
      failseen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      errcnt_q   <= errcnt_d;
      failvec_q  <= failvec_d;
      failseen_q <= failseen_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERRCNT   = errcnt_q;
  assign FAILVEC  = failvec_q;
  assign FAILSEEN = failseen_q;

endmodule

// File: tb/tb_gate2_bist_ctrl.sv
// Scoreboard bench for gate2_bist_ctrl: a nor2 instance with defaults and an xor2 instance
// with SETTLE=1, ITER=70. The cell model is the ideal function XORed with a fault mask.
module tb_gate2_bist_ctrl;

  localparam int NI = 2;
  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0110;
  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam int I0 = 1;
  localparam int I1 = 70;

  typedef struct {
    int         due;
    logic       pass;
    int         errcnt;
    logic [1:0] fv;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [NI];
  logic       y        [NI];
  logic       a        [NI];
  logic       b        [NI];
  logic       busy     [NI];
  logic       done     [NI];
  logic       pass     [NI];
  logic [7:0] errcnt   [NI];
  logic [1:0] failvec  [NI];
  logic       failseen [NI];
  logic [3:0] fmask    [NI];
  logic       busy_prev[NI];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Faulty-cell models.
  assign y[0] = T0[{a[0], b[0]}] ^ fmask[0][{a[0], b[0]}];
  assign y[1] = T1[{a[1], b[1]}] ^ fmask[1][{a[1], b[1]}];

  gate2_bist_ctrl u_nor (
    .CLK(clk), .RST(rst), .START(start[0]), .Y(y[0]), .A(a[0]), .B(b[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERRCNT(errcnt[0]),
    .FAILVEC(failvec[0]), .FAILSEEN(failseen[0])
  );

  gate2_bist_ctrl #(.TRUTH(4'b0110), .SETTLE(1), .ITER(70), .ERRW(8)) u_xor (
    .CLK(clk), .RST(rst), .START(start[1]), .Y(y[1]), .A(a[1]), .B(b[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERRCNT(errcnt[1]),
    .FAILVEC(failvec[1]), .FAILSEEN(failseen[1])
  );

  function automatic int settle_of(int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int iter_of(int i);
    return (i == 0) ? I0 : I1;
  endfunction

  function automatic int lat_of(int i);
    return 4 * iter_of(i) * (settle_of(i) + 1);
  endfunction

  // Result of a run: each faulty vector mismatches once per pass.
  function automatic exp_t model(int i, logic [3:0] m, int due);
    exp_t e;
    int   pop = 0;
    int   total;
    e.due = due;
    e.fv  = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) begin
        e.fv = 2'(k);
        pop++;
      end
    end
    total    = iter_of(i) * pop;
    e.errcnt = (total > 255) ? 255 : total;
    e.fs     = (m != 4'b0000);
    e.pass   = (m == 4'b0000);
    return e;
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, i, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    chk({tag, "_ab"}, i, int'({a[i], b[i]}), 0);
    chk({tag, "_busy"}, i, int'(busy[i]), 0);
    chk({tag, "_done"}, i, int'(done[i]), 0);
    chk({tag, "_pass"}, i, int'(pass[i]), 0);
    chk({tag, "_errcnt"}, i, int'(errcnt[i]), 0);
    chk({tag, "_failvec"}, i, int'(failvec[i]), 0);
    chk({tag, "_failseen"}, i, int'(failseen[i]), 0);
  endtask

  task automatic mon(input int i);
    exp_t f;
    int   s;
    int   k;
    if (busy[i] && !busy_prev[i]) begin
      chk("clr_errcnt", i, int'(errcnt[i]), 0);
      chk("clr_failseen", i, int'(failseen[i]), 0);
      chk("clr_failvec", i, int'(failvec[i]), 0);
      chk("clr_pass", i, int'(pass[i]), 0);
    end
    if (qsize(i) > 0) begin
      f = (i == 0) ? q0[0] : q1[0];
      s = f.due - lat_of(i);
      if (cyc >= s && cyc < f.due) begin
        k = cyc - s;
        chk("busy_run", i, int'(busy[i]), 1);
        chk("ab_vec", i, int'({a[i], b[i]}), (k / (settle_of(i) + 1)) % 4);
      end
      if (cyc == f.due) begin
        chk("done_pulse", i, int'(done[i]), 1);
        chk("busy_fin", i, int'(busy[i]), 0);
        chk("ab_fin", i, int'({a[i], b[i]}), 0);
        chk("pass", i, int'(pass[i]), int'(f.pass));
        chk("errcnt", i, int'(errcnt[i]), f.errcnt);
        chk("failseen", i, int'(failseen[i]), int'(f.fs));
        chk("failvec", i, int'(failvec[i]), int'(f.fv));
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end else if (done[i]) begin
        chk("done_time", i, cyc, f.due);
      end
    end else begin
      chk("no_done_idle", i, int'(done[i]), 0);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) mon(i);
    end
    for (int i = 0; i < NI; i++) busy_prev[i] = busy[i];
  end

  task automatic issue(input int i, input logic [3:0] m);
    @(negedge clk);
    fmask[i] = m;
    start[i] = 1'b1;
    push(i, model(i, m, cyc + 1 + lat_of(i)));
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < lat_of(i) + 20 && qsize(i) != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int i, input logic [3:0] m);
    issue(i, m);
    drain(i);
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      fmask[i]     = 4'b0000;
      busy_prev[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;

    // Directed nor2: ideal, stuck-at-0, inverted.
    run(0, 4'b0000);
    run(0, 4'b0001);
    run(0, 4'b1111);
    // Directed xor2: ideal, stuck-at-1, inverted (saturates).
    run(1, 4'b0000);
    run(1, 4'b1001);
    run(1, 4'b1111);

    // START re-pulsed mid-run is ignored; only one DONE arrives.
    issue(0, 4'b0000);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    drain(0);

    // Reset mid-run kills the run with no DONE.
    issue(0, 4'b0001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    check_zero(0, "rst_mid");
    check_zero(1, "rst_mid");
    rst = 1'b0;
    repeat (lat_of(0) + 4) @(negedge clk);
    run(0, 4'b0000);

    // START held high: three back-to-back runs.
    lat = lat_of(0);
    @(negedge clk);
    n        = cyc;
    fmask[0] = 4'b0000;
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) push(0, model(0, 4'b0000, n + 1 + lat + k * (lat + 2)));
    while (cyc < n + 1 + 2 * (lat + 2) + lat) @(negedge clk);
    start[0] = 1'b0;
    drain(0);

    // Random fault masks.
    for (int r = 0; r < 16; r++) run(0, 4'($urandom_range(0, 15)));
    for (int r = 0; r < 4; r++) run(1, 4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule
